// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared constants for the forwarding scoreboard and its per-source resolver.
//   FWD_REGFILE       fwd_sel encoding meaning "read the register file"
//   DEF_ADDR_W        default register address width
//   DEF_NUM_SRC       default number of source ports (rs, rt, jump rs)
//   DEF_DEPTH         default number of tracked slots (EX, MEM, WB)
//   DEF_LOAD_READY    default lowest slot index where load data is forwardable
//   DEF_CNT_W         default stall counter width
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int FWD_REGFILE    = 0;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_NUM_SRC    = 3;
    localparam int DEF_DEPTH      = 3;
    localparam int DEF_LOAD_READY = 1;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/fwd_src_resolve.sv
// -----------------------------------------------------------------------------
// fwd_src_resolve
// Combinational resolver for one source operand. Finds the youngest in-flight
// slot writing the requested register and reports where to forward from, and
// whether that producer is a load whose data is not available yet.
// Ports:
//   used        in   source is read by the instruction in ID
//   addr        in   source register address
//   slot_vld    in   per-slot valid (slot 0 = youngest)
//   slot_waddr  in   per-slot destination, slot k at [k*ADDR_W +: ADDR_W]
//   slot_load   in   per-slot "producer is a load"
//   sel         out  0 = register file, k+1 = forward from slot k
//   stall       out  winning producer is a load still below LOAD_READY
// -----------------------------------------------------------------------------
module fwd_src_resolve
    import fwd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      used,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DEPTH-1:0]          slot_vld,
    input  logic [DEPTH*ADDR_W-1:0]   slot_waddr,
    input  logic [DEPTH-1:0]          slot_load,
    output logic [SEL_W-1:0]          sel,
    output logic                      stall
);

    logic found;

    // Scan from youngest to oldest; the first hit locks the result so an
    // older, ready producer can never mask a younger, unready load.
    always_comb begin
        sel   = SEL_W'(FWD_REGFILE);
        stall = 1'b0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && used && (addr != '0) && slot_vld[k] &&
                (slot_waddr[k*ADDR_W +: ADDR_W] == addr)) begin
                found = 1'b1;
                sel   = SEL_W'(k + 1);
                stall = slot_load[k] && (k < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
// Hazard/forwarding scoreboard for the MIPS pipeline. In-flight register writes
// age through a DEPTH-slot shift pipeline (slot 0 = EX). Each source operand of
// the instruction in ID is resolved to its youngest producer; a load producer
// that is not yet forwardable raises stall.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   issue_valid  in   instruction leaves ID this cycle
//   issue_wr     in   it writes a register
//   issue_waddr  in   its destination register
//   issue_load   in   it is a load
//   flush        in   squash the instruction leaving ID
//   src_used     in   per-source "is read"
//   src_addr     in   per-source address, field j at [j*ADDR_W +: ADDR_W]
//   fwd_sel      out  per-source forward select, field j at [j*SEL_W +: SEL_W]
//   stall        out  hold PC/IFID, bubble into EX
//   inflight     out  number of valid writing slots
//   stall_cnt    out  saturating count of stall cycles
// -----------------------------------------------------------------------------
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic                        issue_wr,
    input  logic [ADDR_W-1:0]           issue_waddr,
    input  logic                        issue_load,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall,
    output logic [SEL_W-1:0]            inflight,
    output logic [CNT_W-1:0]            stall_cnt
);

    logic [DEPTH-1:0]        slot_vld;
    logic [DEPTH*ADDR_W-1:0] slot_waddr;
    logic [DEPTH-1:0]        slot_load;
    logic [NUM_SRC-1:0]      src_stall;
    logic                    take;

    genvar j;
    generate
        for (j = 0; j < NUM_SRC; j++) begin : g_src
            fwd_src_resolve #(
                .ADDR_W     (ADDR_W),
                .DEPTH      (DEPTH),
                .LOAD_READY (LOAD_READY),
                .SEL_W      (SEL_W)
            ) u_resolve (
                .used       (src_used[j]),
                .addr       (src_addr[j*ADDR_W +: ADDR_W]),
                .slot_vld   (slot_vld),
                .slot_waddr (slot_waddr),
                .slot_load  (slot_load),
                .sel        (fwd_sel[j*SEL_W +: SEL_W]),
                .stall      (src_stall[j])
            );
        end
    endgenerate

    assign stall = |src_stall;

    // Only a real register write is tracked; $0 writes are never recorded.
    assign take = issue_valid && !stall && !flush && issue_wr && (issue_waddr != '0);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight = inflight + SEL_W'(slot_vld[i]);
        end
    end

    // Control state: slot valids and the stall counter. The slots advance
    // every edge regardless of stall, so a stalled load ages toward readiness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld  <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_vld[i] <= slot_vld[i-1];
            end
            slot_vld[0] <= take;
            if (stall && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Slot payload is qualified by slot_vld and needs no reset.
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
            slot_waddr[i*ADDR_W +: ADDR_W] <= slot_waddr[(i-1)*ADDR_W +: ADDR_W];
            slot_load[i]                   <= slot_load[i-1];
        end
        slot_waddr[ADDR_W-1:0] <= issue_waddr;
        slot_load[0]           <= issue_load;
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_wr, issue_load, flush;
    logic [4:0]  issue_waddr;
    logic [2:0]  src_used;
    logic [14:0] src_addr;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic [1:0]  inflight;
    logic [15:0] stall_cnt;

    // Second instance with deep load latency, used only to reach counter saturation.
    logic        b_issue_valid;
    logic [2:0]  b_src_used;
    logic [14:0] b_src_addr;
    logic [11:0] b_fwd_sel;
    logic        b_stall;
    logic [3:0]  b_inflight;
    logic [15:0] b_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    forward_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_waddr (issue_waddr),
        .issue_load  (issue_load),
        .flush       (flush),
        .src_used    (src_used),
        .src_addr    (src_addr),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .inflight    (inflight),
        .stall_cnt   (stall_cnt)
    );

    forward_scoreboard #(.DEPTH(15), .LOAD_READY(15)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (b_issue_valid),
        .issue_wr    (1'b1),
        .issue_waddr (5'd9),
        .issue_load  (1'b1),
        .flush       (1'b0),
        .src_used    (b_src_used),
        .src_addr    (b_src_addr),
        .fwd_sel     (b_fwd_sel),
        .stall       (b_stall),
        .inflight    (b_inflight),
        .stall_cnt   (b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic wr, input logic [4:0] a, input logic ld);
        issue_valid = v;
        issue_wr    = wr;
        issue_waddr = a;
        issue_load  = ld;
    endtask

    task automatic set_src(input int j, input logic u, input logic [4:0] a);
        src_used[j]         = u;
        src_addr[j*5 +: 5]  = a;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 5'd0, 1'b0);
        flush    = 1'b0;
        src_used = '0;
        src_addr = '0;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    initial begin
        rst_n         = 1'b0;
        b_issue_valid = 1'b0;
        b_src_used    = '0;
        b_src_addr    = '0;
        idle();
        #2;
        chk("reset_inflight", 32'(inflight), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ALU chain: add $8, consumer reads rs=$8 as it ages
        issue(1'b1, 1'b1, 5'd8, 1'b0);
        step();
        idle();
        set_src(0, 1'b1, 5'd8);
        #1;
        chk("alu_sel_ex", 32'(fwd_sel[1:0]), 32'd1);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_inflight", 32'(inflight), 32'd1);
        step();
        chk("alu_sel_mem", 32'(fwd_sel[1:0]), 32'd2);
        step();
        chk("alu_sel_wb", 32'(fwd_sel[1:0]), 32'd3);
        step();
        chk("alu_sel_retired", 32'(fwd_sel[1:0]), 32'd0);
        chk("alu_inflight_empty", 32'(inflight), 32'd0);
        drain();

        // Load-use: lw $9, consumer reads rt=$9 and tries to issue
        issue(1'b1, 1'b1, 5'd9, 1'b1);
        step();
        issue(1'b1, 1'b1, 5'd10, 1'b0);
        set_src(1, 1'b1, 5'd9);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_sel_ex", 32'(fwd_sel[3:2]), 32'd1);
        step();
        chk("lu_stall_clear", 32'(stall), 32'd0);
        chk("lu_sel_mem", 32'(fwd_sel[3:2]), 32'd2);
        chk("lu_bubble_inflight", 32'(inflight), 32'd1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        drain();

        // Youngest wins: add $5 in slot0 masks lw $5 in slot1
        issue(1'b1, 1'b1, 5'd5, 1'b1);
        step();
        issue(1'b1, 1'b1, 5'd5, 1'b0);
        step();
        idle();
        set_src(0, 1'b1, 5'd5);
        #1;
        chk("yw_alu_sel", 32'(fwd_sel[1:0]), 32'd1);
        chk("yw_alu_stall", 32'(stall), 32'd0);
        drain();

        // Younger unready lw $5 in slot0, older add $5 in slot1
        issue(1'b1, 1'b1, 5'd5, 1'b0);
        step();
        issue(1'b1, 1'b1, 5'd5, 1'b1);
        step();
        idle();
        set_src(0, 1'b1, 5'd5);
        #1;
        chk("yw_load_stall", 32'(stall), 32'd1);
        chk("yw_load_sel", 32'(fwd_sel[1:0]), 32'd1);
        step();
        chk("yw_load_ready_sel", 32'(fwd_sel[1:0]), 32'd2);
        chk("yw_load_ready_stall", 32'(stall), 32'd0);
        chk("yw_stall_cnt", 32'(stall_cnt), 32'd2);
        drain();

        // Zero register and unused sources
        issue(1'b1, 1'b1, 5'd0, 1'b0);
        step();
        idle();
        chk("zero_dst_inflight", 32'(inflight), 32'd0);
        issue(1'b1, 1'b1, 5'd7, 1'b0);
        step();
        idle();
        chk("r7_inflight", 32'(inflight), 32'd1);
        set_src(0, 1'b1, 5'd0);
        #1;
        chk("src_zero_sel", 32'(fwd_sel[1:0]), 32'd0);
        set_src(0, 1'b0, 5'd7);
        #1;
        chk("src_unused_sel", 32'(fwd_sel[1:0]), 32'd0);
        set_src(2, 1'b1, 5'd7);
        #1;
        chk("jr_src_sel", 32'(fwd_sel[5:4]), 32'd1);
        drain();

        // Flush and stall in the same cycle
        issue(1'b1, 1'b1, 5'd9, 1'b1);
        step();
        issue(1'b1, 1'b1, 5'd11, 1'b0);
        flush = 1'b1;
        set_src(1, 1'b1, 5'd9);
        #1;
        chk("fl_stall", 32'(stall), 32'd1);
        step();
        issue(1'b0, 1'b0, 5'd0, 1'b0);
        flush = 1'b0;
        #1;
        chk("fl_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("fl_inflight", 32'(inflight), 32'd1);
        chk("fl_sel_mem", 32'(fwd_sel[3:2]), 32'd2);
        drain();

        // Reset mid-traffic with three valid slots and a pending stall
        issue(1'b1, 1'b1, 5'd1, 1'b0);
        step();
        issue(1'b1, 1'b1, 5'd2, 1'b0);
        step();
        issue(1'b1, 1'b1, 5'd3, 1'b1);
        step();
        idle();
        set_src(0, 1'b1, 5'd1);
        set_src(1, 1'b1, 5'd3);
        #1;
        chk("mr_inflight_pre", 32'(inflight), 32'd3);
        chk("mr_stall_pre", 32'(stall), 32'd1);
        chk("mr_sel_pre", 32'(fwd_sel), 32'h07);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_inflight", 32'(inflight), 32'd0);
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_sel", 32'(fwd_sel), 32'd0);
        chk("mr_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // Saturation: continuous lw $9 with a rt=$9 consumer stalls 15 of every 16 edges
        b_src_used    = 3'b010;
        b_src_addr    = {5'd0, 5'd9, 5'd0};
        b_issue_valid = 1'b1;
        repeat (16) step();
        chk("sat_first_period", 32'(b_stall_cnt), 32'd15);
        chk("sat_first_stall", 32'(b_stall), 32'd0);
        repeat (70000) step();
        chk("sat_saturated", 32'(b_stall_cnt), 32'hFFFF);
        b_issue_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
